// File: rtl/uart_prg_loader.sv
// Assembles little-endian UART bytes into 32-bit words and writes them to program ROM one cycle after the 4th byte.
// No backpressure: every rx_valid in LOAD is taken; a load ends on idle timeout or on a byte arriving after memory is full.
module uart_prg_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              prg_wea,
  output logic [ADDR_W-1:0] prg_addra,
  output logic [31:0]       prg_dina,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_partial,
  output logic              err_overflow
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TW-1:0]   TMO      = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [23:0]       wbuf, wbuf_d;
  logic [TW-1:0]     tmo_cnt, tmo_cnt_d;
  logic              got_byte, got_byte_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       dina_d;
  logic [ADDR_W:0]   wc_d;
  logic              errp_d, erro_d;

  always_comb begin
    state_d    = state;
    byte_idx_d = byte_idx;
    wbuf_d     = wbuf;
    tmo_cnt_d  = tmo_cnt;
    got_byte_d = got_byte;
    wea_d      = 1'b0;
    addr_d     = prg_addra;
    dina_d     = prg_dina;
    wc_d       = word_count;
    errp_d     = err_partial;
    erro_d     = err_overflow;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          byte_idx_d = 2'd0;
          tmo_cnt_d  = '0;
          got_byte_d = 1'b0;
          wc_d       = '0;
          errp_d     = 1'b0;
          erro_d     = 1'b0;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          got_byte_d = 1'b1;
          tmo_cnt_d  = '0;
          if (word_count == FULL_CNT) begin
            erro_d  = 1'b1;
            state_d = DONE;
          end else if (byte_idx == 2'd3) begin
            wea_d      = 1'b1;
            addr_d     = word_count[ADDR_W-1:0];
            dina_d     = {rx_data, wbuf};
            wc_d       = word_count + 1'b1;
            byte_idx_d = 2'd0;
          end else begin
            case (byte_idx)
              2'd0:    wbuf_d[7:0]   = rx_data;
              2'd1:    wbuf_d[15:8]  = rx_data;
              default: wbuf_d[23:16] = rx_data;
            endcase
            byte_idx_d = byte_idx + 2'd1;
          end
        end else if (got_byte) begin
          // Timeout only arms once the first byte has arrived.
          tmo_cnt_d = tmo_cnt + 1'b1;
          if (tmo_cnt_d == TMO) begin
            state_d = DONE;
            errp_d  = (byte_idx != 2'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      wbuf         <= '0;
      tmo_cnt      <= '0;
      got_byte     <= 1'b0;
      wea_q        <= 1'b0;
      prg_addra    <= '0;
      prg_dina     <= '0;
      word_count   <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      byte_idx     <= byte_idx_d;
      wbuf         <= wbuf_d;
      tmo_cnt      <= tmo_cnt_d;
      got_byte     <= got_byte_d;
      wea_q        <= wea_d;
      prg_addra    <= addr_d;
      prg_dina     <= dina_d;
      word_count   <= wc_d;
      err_partial  <= errp_d;
      err_overflow <= erro_d;
      busy         <= (state_d == LOAD);
      done         <= (state_d == DONE);
    end
  end

  // Reset kills a pending write in the very cycle it is raised.
  assign prg_wea = wea_q & ~reset;

endmodule

// File: tb/tb_uart_prg_loader.sv
// Directed bench for uart_prg_loader with a byte-queue reference model checked every cycle.
module tb_uart_prg_loader;
  localparam int AW    = 3;
  localparam int TMO   = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          prg_wea, busy, done, err_partial, err_overflow;
  logic [AW-1:0] prg_addra;
  logic [31:0]   prg_dina;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  uart_prg_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clock(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .prg_wea(prg_wea), .prg_addra(prg_addra), .prg_dina(prg_dina), .busy(busy), .done(done),
    .word_count(word_count), .err_partial(err_partial), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the bytes of the current load, kept as a queue.
  logic [7:0]  q[$];
  int          idle_n = 0;
  bit          mdl_ok = 0;
  bit          m_busy = 0, m_done = 0, m_wea = 0, m_ep = 0, m_eo = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    m_wea = 0;
    if (reset) begin
      mdl_ok = 1; m_busy = 0; m_done = 0; q.delete(); idle_n = 0;
      m_addr = '0; m_data = '0; m_ep = 0; m_eo = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; q.delete(); idle_n = 0; m_ep = 0; m_eo = 0;
      end
    end else if (rx_valid) begin
      if (q.size() / 4 == DEPTH) begin
        m_eo = 1; m_busy = 0; m_done = 1;
      end else begin
        q.push_back(rx_data);
        idle_n = 0;
        if (q.size() % 4 == 0) begin
          m_wea  = 1;
          m_addr = AW'(q.size() / 4 - 1);
          m_data = {q[q.size()-1], q[q.size()-2], q[q.size()-3], q[q.size()-4]};
        end
      end
    end else if (q.size() > 0) begin
      idle_n++;
      if (idle_n == TMO) begin
        m_busy = 0; m_done = 1; m_ep = (q.size() % 4) != 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("wea",  32'(prg_wea),      32'(m_wea && !reset));
      chk("addr", 32'(prg_addra),    32'(m_addr));
      chk("dina", prg_dina,          m_data);
      chk("wc",   32'(word_count),   32'(q.size() / 4));
      chk("busy", 32'(busy),         32'(m_busy));
      chk("done", 32'(done),         32'(m_done));
      chk("errp", 32'(err_partial),  32'(m_ep));
      chk("erro", 32'(err_overflow), 32'(m_eo));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wc",   32'(word_count), 32'd0);
    chk("rst_dina", prg_dina, 32'd0);

    // Byte in IDLE is ignored; then one word and timeout.
    send(8'hEE);
    pulse_start();
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    @(negedge clk);
    chk("w1_wea",  32'(prg_wea), 32'd1);
    chk("w1_addr", 32'(prg_addra), 32'd0);
    chk("w1_dina", prg_dina, 32'h12345678);
    chk("w1_wc",   32'(word_count), 32'd1);
    repeat (19) tick();
    @(negedge clk);
    chk("tmo_early_done", 32'(done), 32'd0);
    tick();
    @(negedge clk);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_errp", 32'(err_partial), 32'd0);

    // Fill all eight words back-to-back, then overflow.
    pulse_start();
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < 4; k++) send(8'(w * 16 + k));
    @(negedge clk);
    chk("full_addr", 32'(prg_addra), 32'd7);
    chk("full_dina", prg_dina, 32'h73727170);
    chk("full_wc",   32'(word_count), 32'd8);
    chk("full_busy", 32'(busy), 32'd1);
    send(8'hAB);
    @(negedge clk);
    chk("ovf_wea",  32'(prg_wea), 32'd0);
    chk("ovf_erro", 32'(err_overflow), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_wc",   32'(word_count), 32'd8);

    // Six bytes then timeout: partial word dropped.
    pulse_start();
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hA5); send(8'hA6);
    repeat (20) tick();
    @(negedge clk);
    chk("part_done", 32'(done), 32'd1);
    chk("part_errp", 32'(err_partial), 32'd1);
    chk("part_wc",   32'(word_count), 32'd1);
    chk("part_dina", prg_dina, 32'hA4A3A2A1);

    // No bytes for 100 cycles: no timeout; start inside LOAD ignored.
    pulse_start();
    repeat (100) tick();
    @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_done", 32'(done), 32'd0);
    pulse_start();
    send(8'h11); send(8'h22);
    start = 1'b1; send(8'h33); start = 1'b0;
    send(8'h44);
    @(negedge clk);
    chk("ign_addr", 32'(prg_addra), 32'd0);
    chk("ign_dina", prg_dina, 32'h44332211);
    send_word(32'h88776655);
    @(negedge clk);
    chk("ign2_addr", 32'(prg_addra), 32'd1);
    chk("ign2_dina", prg_dina, 32'h88776655);
    repeat (20) tick();

    // In DONE: stray byte dropped; start with coincident byte drops the byte.
    send(8'hEE);
    start = 1'b1; send(8'hDD); start = 1'b0;
    send_word(32'h04030201);
    @(negedge clk);
    chk("coin_addr", 32'(prg_addra), 32'd0);
    chk("coin_dina", prg_dina, 32'h04030201);

    // Reset during the write cycle.
    send_word(32'hA3A2A1A0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_wea", 32'(prg_wea), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_wc",   32'(word_count), 32'd0);
    chk("rstw_addr", 32'(prg_addra), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    pulse_start();
    send_word(32'hCAFEF00D);
    @(negedge clk);
    chk("fresh_wea",  32'(prg_wea), 32'd1);
    chk("fresh_addr", 32'(prg_addra), 32'd0);
    chk("fresh_dina", prg_dina, 32'hCAFEF00D);
    repeat (25) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_prg_loader.md
UART_PRG_LOADER -- requirements
Module: uart_prg_loader

Interface
REQ-001 Parameter ADDR_W, default 14: instruction-memory word-address width; capacity 2^ADDR_W 32-bit words.
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000: idle cycles after the last accepted byte that end a load.
REQ-003 clock  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a new load.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-008 prg_wea  output  1  prgrom write enable; one-cycle pulse per word.
REQ-009 prg_addra  output  ADDR_W  prgrom word address.
REQ-010 prg_dina  output  32  prgrom write data.
REQ-011 busy  output  1  high while in LOAD.
REQ-012 done  output  1  high in DONE; remains high until the next start or reset.
REQ-013 word_count  output  ADDR_W+1  number of words written in the current or last load.
REQ-014 err_partial  output  1  load ended with 1-3 bytes of an incomplete word.
REQ-015 err_overflow  output  1  a byte arrived after memory was full.

Function
REQ-016 States SHALL be IDLE, LOAD and DONE, with all outputs registered.
REQ-017 IDLE/DONE + start -> LOAD: byte index, word_count, timeout counter and both error flags clear; done=0.
REQ-018 In IDLE and DONE, rx_valid SHALL be ignored; if start and rx_valid coincide, start wins and the byte is dropped.
REQ-019 In LOAD, start SHALL be ignored.
REQ-020 In LOAD, each rx_valid accepts one byte, little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-021 The cycle after the 4th byte of a word is accepted: prg_wea=1 for exactly one cycle, prg_addra=word_count[ADDR_W-1:0] and prg_dina=the assembled word; word_count increments in that same cycle.
REQ-022 prg_addra and prg_dina SHALL hold their values when prg_wea=0.
REQ-023 prg_wea SHALL never be asserted outside that write cycle.
REQ-024 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no loss.
REQ-025 Before the first byte of a load, LOAD waits indefinitely; no timeout applies.
REQ-026 After the first byte, the timeout counter restarts on every accepted byte and otherwise increments.
REQ-027 When the timeout counter reaches TIMEOUT_CYC -> DONE; err_partial=1 if the byte index is nonzero, and the partial word is discarded and not written.
REQ-028 Full condition: word_count = 2^ADDR_W. A byte accepted while full SHALL be dropped, set err_overflow=1 and go to DONE next cycle; no write occurs and the address never wraps.
REQ-029 Reaching full alone SHALL NOT end the load; only a timeout or an overflow byte does.
REQ-030 word_count SHALL saturate at 2^ADDR_W.
REQ-031 busy=1 iff state=LOAD; done=1 iff state=DONE.

Reset
REQ-032 On reset: state=IDLE; prg_wea=0; prg_addra=0; prg_dina=0; busy=0; done=0; word_count=0; err_partial=0; err_overflow=0; byte index=0; timeout counter=0.
REQ-033 Reset SHALL take priority over all inputs; reset mid-LOAD abandons the load, including any pending write, and writes nothing in the reset cycle.

Verification (TIMEOUT_CYC=20, ADDR_W=3 unless stated)
REQ-034 start, then bytes 78,56,34,12 on consecutive cycles -> one cycle later prg_wea=1, prg_addra=0, prg_dina=0x12345678, word_count=1; after 20 idle cycles done=1, err_partial=0.
REQ-035 Eight words streamed back-to-back, 32 strobes -> eight prg_wea pulses at addresses 0..7 with correct data, word_count=8; a 33rd byte -> err_overflow=1, no write, then DONE.
REQ-036 start, then 6 bytes, then idle -> one write at address 0; DONE after 20 idle cycles; err_partial=1, word_count=1.
REQ-037 start held with no bytes for 100 cycles -> stays in LOAD, busy=1, done=0.
REQ-038 rx_valid in IDLE; start coincident with rx_valid; start during LOAD -> byte dropped, start wins, start ignored; verified by addresses/data of subsequent writes.
REQ-039 reset asserted in the cycle after the 4th byte -> prg_wea=0 in that cycle; all outputs at reset values next cycle; a fresh start then loads from address 0.
